round_sequencer: RTL and testbench

Game-round scheduler for the rhythm-game pipeline. It runs on the divided panel clock and sequences one play round: idle, countdown, play, optional pause, and result. During play it issues the note-scroll step ticks that pace the note shifter and judge, latches the chosen song, clears the score at round start, and ends the round on the shifter's finish flag or on abort.

---
 rtl/round_sequencer.sv | 173 +++++++++++++++++
 tb/tb_round_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - play-round scheduler: countdown, scroll step ticks, result hold
// Optional PLAY/PAUSE toggling on pause_btn rising edges is built when ROUND_PAUSE_EN is defined.
module round_sequencer #(
  parameter int unsigned STEP_DIV        = 1000,
  parameter int unsigned COUNTDOWN_STEPS = 3,
  parameter int unsigned RESULT_HOLD     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  song_id,
  input  logic        finish_in,
  input  logic        abort,
  input  logic        pause_btn,
  output logic [2:0]  phase,
  output logic [1:0]  song_latched,
  output logic [1:0]  countdown,
  output logic        step_tick,
  output logic [15:0] step_count,
  output logic        score_clr
);
  localparam int unsigned DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [1:0]        CD_INIT   = 2'(COUNTDOWN_STEPS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    RESULT    = 3'd3,
    PAUSE     = 3'd4
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [1:0]        song_q, song_d;
  logic [1:0]        countdown_q, countdown_d;
  logic              step_tick_q, step_tick_d;
  logic [15:0]       step_count_q, step_count_d;
  logic              score_clr_q, score_clr_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [31:0] period;
  logic        div_last;
  logic        pause_edge;

  assign period   = STEP_DIV >> song_q;
  assign div_last = (32'(div_cnt_q) == period - 32'd1);

`ifdef ROUND_PAUSE_EN
  logic pause_prev_q;

  always_ff @(posedge clk) begin
    if (rst) pause_prev_q <= 1'b0;
    else     pause_prev_q <= pause_btn;
  end

  assign pause_edge = pause_btn & ~pause_prev_q;
`else
  logic unused_pause_btn;
  assign unused_pause_btn = pause_btn;
  assign pause_edge       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= IDLE;
      song_q       <= 2'd0;
      countdown_q  <= 2'd0;
      step_tick_q  <= 1'b0;
      step_count_q <= 16'd0;
      score_clr_q  <= 1'b0;
      div_cnt_q    <= '0;
      hold_cnt_q   <= '0;
    end else begin
      phase_q      <= phase_d;
      song_q       <= song_d;
      countdown_q  <= countdown_d;
      step_tick_q  <= step_tick_d;
      step_count_q <= step_count_d;
      score_clr_q  <= score_clr_d;
      div_cnt_q    <= div_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE: begin
        if (start && song_id != 2'd3) phase_d = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (abort)                              phase_d = IDLE;
        else if (div_last && countdown_q == 2'd1) phase_d = PLAY;
      end
      PLAY: begin
        if (abort)           phase_d = IDLE;
        else if (finish_in)  phase_d = RESULT;
        else if (pause_edge) phase_d = PAUSE;
      end
      PAUSE: begin
        if (abort)           phase_d = IDLE;
        else if (finish_in)  phase_d = RESULT;
        else if (pause_edge) phase_d = PLAY;
      end
      RESULT: begin
        // A start here only dismisses the result screen; it never opens a round.
        if (abort || start)                         phase_d = IDLE;
        else if (div_last && hold_cnt_q == HOLD_LAST) phase_d = IDLE;
      end
      default: phase_d = IDLE;
    endcase
  end

  always_comb begin
    song_d       = song_q;
    countdown_d  = countdown_q;
    step_tick_d  = 1'b0;
    step_count_d = step_count_q;
    score_clr_d  = 1'b0;
    div_cnt_d    = div_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    case (phase_q)
      IDLE: begin
        div_cnt_d = '0;
        if (phase_d == COUNTDOWN) begin
          song_d       = song_id;
          countdown_d  = CD_INIT;
          step_count_d = 16'd0;
          score_clr_d  = 1'b1;
        end
      end
      COUNTDOWN: begin
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        if (div_last) countdown_d = countdown_q - 2'd1;
      end
      PLAY: begin
        if (phase_d == PLAY) begin
          div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
          if (div_last) begin
            step_tick_d = 1'b1;
            if (step_count_q != 16'hFFFF) step_count_d = step_count_q + 16'd1;
          end
        end else if (phase_d != PAUSE) begin
          div_cnt_d = '0;
        end
      end
      PAUSE: begin
        if (phase_d != PLAY && phase_d != PAUSE) div_cnt_d = '0;
      end
      RESULT: begin
        if (phase_d == RESULT) begin
          div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
          if (div_last) hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
        end
      end
      default: div_cnt_d = '0;
    endcase
    if (phase_d == RESULT && phase_q != RESULT) hold_cnt_d = '0;
    if (phase_d == IDLE && phase_q != IDLE)     countdown_d = 2'd0;
  end

  assign phase        = phase_q;
  assign song_latched = song_q;
  assign countdown    = countdown_q;
  assign step_tick    = step_tick_q;
  assign step_count   = step_count_q;
  assign score_clr    = score_clr_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed self-checking bench for round_sequencer
// Pause expectations follow ROUND_PAUSE_EN the same way the design does.
module tb_round_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  song_id = 2'd0;
  logic        finish_in = 1'b0;
  logic        abort = 1'b0;
  logic        pause_btn = 1'b0;
  logic [2:0]  phase;
  logic [1:0]  song_latched;
  logic [1:0]  countdown;
  logic        step_tick;
  logic [15:0] step_count;
  logic        score_clr;

`ifdef ROUND_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  round_sequencer #(.STEP_DIV(8), .COUNTDOWN_STEPS(3), .RESULT_HOLD(4)) dut (
    .clk(clk), .rst(rst), .start(start), .song_id(song_id), .finish_in(finish_in),
    .abort(abort), .pause_btn(pause_btn), .phase(phase), .song_latched(song_latched),
    .countdown(countdown), .step_tick(step_tick), .step_count(step_count), .score_clr(score_clr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ck_phase(input string tag, input int exp); chk(tag, 32'(phase), 32'(exp)); endtask
  task automatic ck_cd(input string tag, input int exp);    chk(tag, 32'(countdown), 32'(exp)); endtask
  task automatic ck_tick(input string tag, input int exp);  chk(tag, 32'(step_tick), 32'(exp)); endtask
  task automatic ck_cnt(input string tag, input int exp);   chk(tag, 32'(step_count), 32'(exp)); endtask
  task automatic ck_clr(input string tag, input int exp);   chk(tag, 32'(score_clr), 32'(exp)); endtask
  task automatic ck_song(input string tag, input int exp);  chk(tag, 32'(song_latched), 32'(exp)); endtask

  task automatic ck_reset_values(input string tag);
    ck_phase({tag, "_phase"}, 0);
    ck_song({tag, "_song"}, 0);
    ck_cd({tag, "_countdown"}, 0);
    ck_tick({tag, "_tick"}, 0);
    ck_cnt({tag, "_count"}, 0);
    ck_clr({tag, "_clr"}, 0);
  endtask

  initial begin
    int exp_div;
    int exp_cnt;
    bit paused;

    // Reset
    step(2);
    ck_reset_values("reset");
    rst = 1'b0;
    step(1);
    ck_phase("idle_after_reset", 0);

    // Song 0: countdown 3/2/1 for 8 cycles each, PLAY at +24, ticks every 8
    start = 1'b1; song_id = 2'd0;
    step(1);
    start = 1'b0;
    ck_phase("s0_enter_cd", 1);
    ck_clr("s0_clr_pulse", 1);
    ck_cd("s0_cd_init", 3);
    ck_cnt("s0_count_clear", 0);
    for (int k = 1; k < 24; k++) begin
      step(1);
      if (k == 1) ck_clr("s0_clr_one_cycle", 0);
      ck_phase("s0_cd_phase", 1);
      ck_cd("s0_cd_value", 3 - k / 8);
    end
    step(1);
    ck_phase("s0_play_at_24", 2);
    ck_cd("s0_cd_zero", 0);
    for (int k = 1; k <= 24; k++) begin
      step(1);
      ck_tick("s0_tick", (k % 8 == 0) ? 1 : 0);
      ck_cnt("s0_count", k / 8);
    end
    step(16);
    ck_tick("s0_tick5", 1);
    ck_cnt("s0_count5", 5);

    // finish after 5 ticks -> RESULT, IDLE 32 cycles later
    finish_in = 1'b1;
    step(1);
    finish_in = 1'b0;
    ck_phase("s0_result", 3);
    ck_cnt("s0_result_count", 5);
    step(31);
    ck_phase("s0_result_hold31", 3);
    step(1);
    ck_phase("s0_auto_idle", 0);
    ck_cnt("s0_idle_count_hold", 5);
    ck_song("s0_idle_song_hold", 0);

    // Song 2: P=2, ticks every 2 cycles; start in RESULT dismisses
    start = 1'b1; song_id = 2'd2;
    step(1);
    start = 1'b0;
    ck_phase("s2_enter_cd", 1);
    ck_song("s2_song", 2);
    ck_clr("s2_clr", 1);
    ck_cnt("s2_count_clear", 0);
    step(5);
    ck_cd("s2_cd_at5", 1);
    step(1);
    ck_phase("s2_play_at_6", 2);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      ck_tick("s2_tick", (k % 2 == 0) ? 1 : 0);
      ck_cnt("s2_count", k / 2);
    end
    finish_in = 1'b1;
    step(1);
    finish_in = 1'b0;
    ck_phase("s2_result", 3);
    ck_cnt("s2_result_count", 5);
    step(3);
    ck_phase("s2_result_still", 3);
    start = 1'b1; song_id = 2'd0;
    step(1);
    start = 1'b0;
    ck_phase("s2_start_in_result", 0);
    ck_clr("s2_no_clr", 0);
    ck_song("s2_song_held", 2);
    step(1);
    ck_phase("s2_start_consumed", 0);
    ck_clr("s2_no_clr_later", 0);

    // song_id 3 is ignored
    start = 1'b1; song_id = 2'd3;
    step(1);
    start = 1'b0;
    ck_phase("s3_ignored", 0);
    ck_clr("s3_no_clr", 0);
    ck_song("s3_song_unchanged", 2);

    // abort in COUNTDOWN
    start = 1'b1; song_id = 2'd0;
    step(1);
    start = 1'b0;
    step(3);
    ck_cd("abort_cd_before", 3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    ck_phase("abort_cd_idle", 0);
    ck_cd("abort_cd_zero", 0);

    // abort together with finish_in in PLAY -> IDLE wins
    start = 1'b1; song_id = 2'd2;
    step(1);
    start = 1'b0;
    step(6);
    ck_phase("abfin_play", 2);
    abort = 1'b1; finish_in = 1'b1;
    step(1);
    abort = 1'b0; finish_in = 1'b0;
    ck_phase("abfin_idle", 0);

    // rst mid-PLAY, then a clean round
    start = 1'b1; song_id = 2'd1;
    step(1);
    start = 1'b0;
    step(12);
    ck_phase("rst_play", 2);
    step(4);
    ck_tick("rst_s1_tick", 1);
    ck_cnt("rst_s1_count", 1);
    rst = 1'b1;
    step(1);
    ck_reset_values("rst_mid");
    rst = 1'b0;
    step(1);
    ck_reset_values("rst_release");
    start = 1'b1; song_id = 2'd0;
    step(1);
    start = 1'b0;
    ck_phase("clean_cd", 1);
    ck_clr("clean_clr", 1);
    ck_cd("clean_cd_init", 3);
    step(24);
    ck_phase("clean_play", 2);
    step(8);
    ck_tick("clean_tick", 1);
    ck_cnt("clean_count", 1);

    // Pause edge at div_cnt = 5
    step(5);
    exp_div = 5;
    exp_cnt = 1;
    paused  = 1'b0;
    pause_btn = 1'b1;
    step(1);
    if (PAUSE_ON) paused = 1'b1;
    else          exp_div = (exp_div + 1) % 8;
    ck_phase("pause_enter", paused ? 4 : 2);
    ck_tick("pause_enter_tick", 0);
    for (int i = 0; i < 100; i++) begin
      if (i == 10) pause_btn = 1'b0;
      step(1);
      if (!paused) begin
        exp_div = (exp_div + 1) % 8;
        if (exp_div == 0) exp_cnt++;
      end
      ck_tick("pause_hold_tick", (!paused && exp_div == 0) ? 1 : 0);
      ck_cnt("pause_hold_count", exp_cnt);
    end
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
    if (paused) begin
      paused = 1'b0;
    end else begin
      exp_div = (exp_div + 1) % 8;
      if (exp_div == 0) exp_cnt++;
    end
    ck_phase("pause_resume", 2);
    ck_tick("pause_resume_tick", (exp_div == 0) ? 1 : 0);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      exp_div = (exp_div + 1) % 8;
      if (exp_div == 0) exp_cnt++;
      ck_tick("resume_tick", (exp_div == 0) ? 1 : 0);
      ck_cnt("resume_count", exp_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
